// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stage: op encodings, FSM states and
// the small decode helpers used by the FSM and the lane logic.
package dmem_pkg;

  localparam logic [1:0] OP_LDW = 2'b00;
  localparam logic [1:0] OP_LDB = 2'b01;
  localparam logic [1:0] OP_STW = 2'b10;
  localparam logic [1:0] OP_STB = 2'b11;

  localparam int MEM_EN_BIT      = 2;
  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  function automatic logic is_store(input logic [1:0] op);
    return (op == OP_STW) || (op == OP_STB);
  endfunction

  function automatic logic is_word(input logic [1:0] op);
    return (op == OP_LDW) || (op == OP_STW);
  endfunction

endpackage

// File: rtl/dmem_stage_if.sv
// Ready-handshaked data-memory port. The stage is the master; the memory
// (or the bench's memory model) is the slave.
interface dmem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/dmem_lane.sv
// Little-endian byte-lane steering: store byte enables and replication on the
// way out, load byte select and sign extension on the way back.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  i_op,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_store,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [7:0] w_byte;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_lane)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  always_comb begin
    o_be    = 4'hF;
    o_wdata = 32'h0;
    o_ldata = i_rdata;
    if (i_op == OP_STB) begin
      o_be    = 4'b0001 << i_lane;
      o_wdata = {4{i_store[7:0]}};
    end else if (i_op == OP_STW) begin
      o_wdata = i_store;
    end else if (i_op == OP_LDB) begin
      o_ldata = {{24{w_byte[7]}}, w_byte};
    end
  end

endmodule

// File: rtl/dmem_stage.sv
// Data-memory stage: accepts one ALU record at a time, performs the load or
// store over the memory port, and emits a single registered writeback record.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | in_ready high, waiting for in_valid
//   S_ACCESS | mem_req high, waiting for mem_ready or the timeout
//   S_DONE   | wb_valid (and any error flag) high for this one cycle
module dmem_stage
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_store,
  input  logic [4:0]  in_regD,
  dmem_stage_if.master mem,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        err_misalign,
  output logic        err_bus
);

  localparam logic [7:0] TC_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [1:0]  r_op;
  logic [1:0]  r_lane;
  logic [7:0]  r_cnt;
  logic        r_in_ready;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;
  logic        r_wb_valid;
  logic        r_wb_en;
  logic [4:0]  r_wb_reg;
  logic [31:0] r_wb_data;
  logic        r_err_mis;
  logic        r_err_bus;

  logic [1:0]  w_lane_op;
  logic [1:0]  w_lane;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;

  // In IDLE the lane logic steers the incoming record; afterwards the held one.
  assign w_lane_op = (r_state == S_IDLE) ? in_op[1:0]  : r_op;
  assign w_lane    = (r_state == S_IDLE) ? in_alu[1:0] : r_lane;

  dmem_lane u_lane (
    .i_op    (w_lane_op),
    .i_lane  (w_lane),
    .i_store (in_store),
    .i_rdata (mem.mem_rdata),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_ldata (w_ldata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= OP_LDW;
      r_lane      <= 2'd0;
      r_cnt       <= 8'd0;
      r_in_ready  <= 1'b1;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_be    <= 4'h0;
      r_mem_wdata <= 32'h0;
      r_wb_valid  <= 1'b0;
      r_wb_en     <= 1'b0;
      r_wb_reg    <= 5'd0;
      r_wb_data   <= 32'h0;
      r_err_mis   <= 1'b0;
      r_err_bus   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            r_op       <= in_op[1:0];
            r_lane     <= in_alu[1:0];
            r_wb_reg   <= in_regD;
            r_cnt      <= 8'd0;
            if (!in_op[MEM_EN_BIT]) begin
              r_state    <= S_DONE;
              r_wb_valid <= 1'b1;
              r_wb_en    <= 1'b1;
              r_wb_data  <= in_alu;
            end else if (is_word(in_op[1:0]) && (in_alu[1:0] != 2'b00)) begin
              r_state    <= S_DONE;
              r_wb_valid <= 1'b1;
              r_wb_en    <= 1'b0;
              r_wb_data  <= 32'h0;
              r_err_mis  <= 1'b1;
            end else begin
              r_state     <= S_ACCESS;
              r_mem_req   <= 1'b1;
              r_mem_we    <= is_store(in_op[1:0]);
              r_mem_addr  <= {in_alu[31:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
            end
          end
        end

        S_ACCESS: begin
          // A ready on the last counted cycle wins over the timeout.
          if (mem.mem_ready) begin
            r_state    <= S_DONE;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_wb_valid <= 1'b1;
            r_wb_en    <= !is_store(r_op);
            r_wb_data  <= is_store(r_op) ? 32'h0 : w_ldata;
          end else if (r_cnt == TC_LAST) begin
            r_state    <= S_DONE;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_wb_valid <= 1'b1;
            r_wb_en    <= 1'b0;
            r_wb_data  <= 32'h0;
            r_err_bus  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_DONE: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
          r_wb_valid <= 1'b0;
          r_wb_en    <= 1'b0;
          r_err_mis  <= 1'b0;
          r_err_bus  <= 1'b0;
        end

        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
          r_mem_req  <= 1'b0;
          r_mem_we   <= 1'b0;
          r_wb_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_be    = r_mem_be;
  assign mem.mem_wdata = r_mem_wdata;
  assign wb_valid      = r_wb_valid;
  assign wb_en         = r_wb_en;
  assign wb_reg        = r_wb_reg;
  assign wb_data       = r_wb_data;
  assign err_misalign  = r_err_mis;
  assign err_bus       = r_err_bus;

endmodule
